// File: rtl/br_arb_rr_lock_pkg.sv
// Shared arbiter types and helpers: lock FSM state encoding, round-robin pointer
// advance and the clamped clog2 used to size binary grant indices.
package br_arb_pkg;

  typedef enum logic {Idle, Locked} br_arb_lock_state_e;

  // Width needed for a binary index of n values, never less than 1.
  function automatic int unsigned clamped_clog2(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Round-robin pointer advance: the slot after idx, wrapping at n.
  function automatic int unsigned rr_next_ptr(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/br_arb_rr_lock_enc.sv
// Onehot-to-binary encoder; the output is 0 for an all-zero input.
module br_enc_onehot2bin #(
  parameter int NumValues = 2,
  parameter int BinWidth  = 1
) (
  input  logic [NumValues-1:0] in_i,
  output logic [BinWidth-1:0]  out_o
);

  // OR-reduction of set indices; exact because the input is onehot0.
  always_comb begin
    out_o = '0;
    for (int unsigned i = 0; i < NumValues; i++) begin
      if (in_i[i]) out_o = out_o | BinWidth'(i);
    end
  end

endmodule

// File: rtl/br_arb_rr_lock.sv
// Round-robin arbiter that locks the grant across a multi-beat packet.
// Optional beat limit enabled by BR_ARB_RR_LOCK_MAX_HOLD_EN (forced release after MaxHold beats).
module br_arb_rr_lock
  import br_arb_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int BinWidth      = clamped_clog2(NumRequesters),
  parameter int MaxHold       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumRequesters-1:0] request,
  input  logic [NumRequesters-1:0] request_last,
  input  logic                     resource_ready,
  output logic [NumRequesters-1:0] grant,
  output logic                     grant_valid,
  output logic [BinWidth-1:0]      grant_idx,
  output logic                     xfer,
  output logic                     forced_release
);

  if (NumRequesters < 2) begin : g_chk_num
    $error("br_arb_rr_lock: NumRequesters must be >= 2");
  end
  if (BinWidth < clamped_clog2(NumRequesters) || BinWidth >= 32) begin : g_chk_bin
    $error("br_arb_rr_lock: BinWidth out of range");
  end
  if (MaxHold < 1) begin : g_chk_hold
    $error("br_arb_rr_lock: MaxHold must be >= 1");
  end

  br_arb_lock_state_e         state_q, state_d;
  logic [NumRequesters-1:0]   grant_q, grant_d;
  logic [BinWidth-1:0]        ptr_q, ptr_d;
  logic [BinWidth-1:0]        pick_idx;
  logic                       pick_found;
  int unsigned                cand;
  logic                       last_hit;
  logic                       hold_hit;
  logic                       release_w;

  br_enc_onehot2bin #(
    .NumValues(NumRequesters),
    .BinWidth (BinWidth)
  ) u_enc (
    .in_i (grant_q),
    .out_o(grant_idx)
  );

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  // grant_q is onehot0, so masking selects request/last of the grant holder.
  assign xfer        = grant_valid & (|(request & grant_q)) & resource_ready;
  assign last_hit    = |(request_last & grant_q);
  assign release_w   = xfer & (last_hit | hold_hit);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < NumRequesters; off++) begin
      cand = (32'(ptr_q) + off) % NumRequesters;
      if (!pick_found && request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = BinWidth'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      Idle: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = Locked;
        end
      end
      Locked: begin
        if (release_w) begin
          grant_d = '0;
          state_d = Idle;
          ptr_d   = BinWidth'(rr_next_ptr(32'(grant_idx), NumRequesters));
        end
      end
      default: begin
        grant_d = '0;
        state_d = Idle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Idle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef BR_ARB_RR_LOCK_MAX_HOLD_EN
  localparam int CntWidth = $clog2(MaxHold + 1);

  logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;

  // Every grant passes through Idle, so clearing there resets the count per lock.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == Idle)  beat_cnt_d = '0;
    else if (xfer)        beat_cnt_d = beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign hold_hit       = (beat_cnt_q == CntWidth'(MaxHold - 1)) & ~last_hit;
  assign forced_release = xfer & hold_hit;
`else
  assign hold_hit       = 1'b0;
  assign forced_release = 1'b0;
`endif

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_idx_range     : assert property (@(posedge clk) disable iff (rst) 32'(grant_idx) < NumRequesters);
  a_lock_stable   : assert property (@(posedge clk) disable iff (rst)
                                     (state_q == Locked && !release_w) |=> $stable(grant_q));
  a_req_held      : assert property (@(posedge clk) disable iff (rst)
                                     grant_valid |-> |(request & grant_q));

endmodule

// File: tb/tb_br_arb_rr_lock.sv
// Self-checking bench for br_arb_rr_lock (NumRequesters=4, MaxHold=3), directed scenarios
// plus randomized traffic against a lock-owner reference model.
module tb_br_arb_rr_lock;

  localparam int N  = 4;
  localparam int MH = 3;
  localparam int BW = 2;
`ifdef BR_ARB_RR_LOCK_MAX_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  request, request_last;
  logic          resource_ready;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [BW-1:0] grant_idx;
  logic          xfer, forced_release;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which requester owns the resource (-1 none), rotation start, beats taken.
  int m_owner, m_ptr, m_beats;

  always #5 clk = ~clk;

  br_arb_rr_lock #(
    .NumRequesters(N),
    .BinWidth     (BW),
    .MaxHold      (MH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .request_last  (request_last),
    .resource_ready(resource_ready),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .xfer          (xfer),
    .forced_release(forced_release)
  );

  function automatic logic m_xfer();
    if (m_owner < 0) return 1'b0;
    return request[m_owner] && resource_ready;
  endfunction

  function automatic logic m_forced();
    if (!m_xfer()) return 1'b0;
    return HoldEn && (m_beats == MH - 1) && !request_last[m_owner];
  endfunction

  function automatic int m_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [BW-1:0] m_idx();
    return (m_owner < 0) ? '0 : BW'(m_owner);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_beats <= 0;
    end else if (m_owner < 0) begin
      if (request != '0) begin
        m_owner <= m_pick(request, m_ptr);
        m_beats <= 0;
      end
    end else if (m_xfer()) begin
      if (request_last[m_owner] || m_forced()) begin
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= -1;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  // Stimulus only: finish any open lock with a last beat, then one quiet cycle.
  task automatic drain();
    @(negedge clk);
    request        = (m_owner >= 0) ? m_grant() : '0;
    request_last   = '1;
    resource_ready = 1'b1;
    @(negedge clk);
    request        = '0;
    request_last   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; request = '0; request_last = '0; resource_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (grant !== '0)        begin n_bad++; $display("FAIL reset_grant got=%b want=0", grant); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", grant_valid); end
    n_cmp++; if (grant_idx !== '0)     begin n_bad++; $display("FAIL reset_idx got=%0d want=0", grant_idx); end
    n_cmp++; if (xfer !== 1'b0 || forced_release !== 1'b0)
      begin n_bad++; $display("FAIL reset_xfer got=%b%b want=00", xfer, forced_release); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [N-1:0] eg [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
    logic [BW-1:0] ei [4] = '{2'd0, 2'd1, 2'd0, 2'd3};
    logic ex [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      request = 4'b1010; request_last = '1; resource_ready = 1'b1;
      #1;
      n_cmp++; if (grant !== eg[c])     begin n_bad++; $display("FAIL basic_grant cyc=%0d got=%b want=%b", c, grant, eg[c]); end
      n_cmp++; if (grant_idx !== ei[c]) begin n_bad++; $display("FAIL basic_idx cyc=%0d got=%0d want=%0d", c, grant_idx, ei[c]); end
      n_cmp++; if (xfer !== ex[c])      begin n_bad++; $display("FAIL basic_xfer cyc=%0d got=%b want=%b", c, xfer, ex[c]); end
    end
    drain();
  endtask

  task automatic test_multibeat();
    logic rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] eg;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      request        = (c < 6) ? 4'b0100 : 4'b0000;
      request_last   = (c == 5) ? 4'b0100 : 4'b0000;
      resource_ready = rdy[c];
      #1;
      eg = (c >= 1 && c <= 5) ? 4'b0100 : 4'b0000;
      n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL multibeat_grant cyc=%0d got=%b want=%b", c, grant, eg); end
      n_cmp++; if (xfer !== (c >= 1 && c <= 5 && rdy[c]))
        begin n_bad++; $display("FAIL multibeat_xfer cyc=%0d got=%b want=%b", c, xfer, (c >= 1 && c <= 5 && rdy[c])); end
      n_cmp++; if (forced_release !== 1'b0)
        begin n_bad++; $display("FAIL multibeat_forced cyc=%0d got=%b want=0", c, forced_release); end
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [N-1:0] eg [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      request = 4'b1001; request_last = '1; resource_ready = (c != 0);
      #1;
      n_cmp++; if (grant !== eg[c]) begin n_bad++; $display("FAIL wrap_grant cyc=%0d got=%b want=%b", c, grant, eg[c]); end
    end
    drain();
  endtask

  task automatic test_reset_midlock();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      request = 4'b0010; request_last = '0; resource_ready = 1'b1;
      #1;
      n_cmp++; if (grant !== (c == 1 ? 4'b0010 : 4'b0000))
        begin n_bad++; $display("FAIL midlock_pre cyc=%0d got=%b", c, grant); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (grant !== '0)    begin n_bad++; $display("FAIL midlock_grant got=%b want=0", grant); end
    n_cmp++; if (grant_idx !== '0) begin n_bad++; $display("FAIL midlock_idx got=%0d want=0", grant_idx); end
    n_cmp++; if (xfer !== 1'b0)    begin n_bad++; $display("FAIL midlock_xfer got=%b want=0", xfer); end
    @(negedge clk);
    rst = 1'b0; request = 4'b0110;
    @(negedge clk);
    #1;
    n_cmp++; if (grant !== 4'b0010 || grant_idx !== 2'd1)
      begin n_bad++; $display("FAIL midlock_regrant got=%b/%0d want=0010/1", grant, grant_idx); end
    drain();
  endtask

  task automatic test_max_hold();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      request = 4'b0011; request_last = '0; resource_ready = 1'b1;
      #1;
      n_cmp++; if (grant !== m_grant()) begin n_bad++; $display("FAIL hold_grant cyc=%0d got=%b want=%b", c, grant, m_grant()); end
      n_cmp++; if (xfer !== m_xfer())   begin n_bad++; $display("FAIL hold_xfer cyc=%0d got=%b want=%b", c, xfer, m_xfer()); end
      n_cmp++; if (forced_release !== m_forced())
        begin n_bad++; $display("FAIL hold_forced cyc=%0d got=%b want=%b", c, forced_release, m_forced()); end
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      request        = N'($urandom) | ((m_owner >= 0) ? m_grant() : '0);
      request_last   = N'($urandom) & N'($urandom) & N'($urandom);
      resource_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (grant !== m_grant())  begin n_bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", c, grant, m_grant()); end
      n_cmp++; if (grant_idx !== m_idx()) begin n_bad++; $display("FAIL rand_idx cyc=%0d got=%0d want=%0d", c, grant_idx, m_idx()); end
      n_cmp++; if (grant_valid !== (m_owner >= 0))
        begin n_bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, grant_valid, (m_owner >= 0)); end
      n_cmp++; if (xfer !== m_xfer())    begin n_bad++; $display("FAIL rand_xfer cyc=%0d got=%b want=%b", c, xfer, m_xfer()); end
      n_cmp++; if (forced_release !== m_forced())
        begin n_bad++; $display("FAIL rand_forced cyc=%0d got=%b want=%b", c, forced_release, m_forced()); end
      n_cmp++; if ($countones(grant) > 1 || (grant_valid && grant[grant_idx] !== 1'b1))
        begin n_bad++; $display("FAIL rand_onehot cyc=%0d grant=%b idx=%0d want onehot0 matching idx", c, grant, grant_idx); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multibeat();
    test_wrap();
    test_reset_midlock();
    test_max_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
